mux_sequencer: RTL



---
 rtl/mux_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mux_sequencer.sv
// Transmit-side sequencer that drives the 10-way symbol mux select every clock.
// Frames upstream bytes with STP/END/EDB, pads frames to ALIGN symbols and inserts periodic COM+SKP sets.
module mux_sequencer #(
    parameter int SKP_INTERVAL = 16,
    parameter int SKP_COUNT    = 3,
    parameter int ALIGN        = 4
) (
    input  logic       seqCLK,
    input  logic       seqRST_n,
    input  logic       tlpVLD,
    input  logic       tlpLAST,
    output logic       tlpRDY,
    output logic [3:0] muxCTRL,
    output logic       seqBUSY
);

    // state    | meaning
    // IDLE     | link idle, IDL symbols; chooses skip or new frame
    // SKP_COM  | COM symbol opening a skip ordered set
    // SKP_SYM  | SKP symbols, SKP_COUNT cycles
    // STP      | start-of-frame symbol
    // DATA     | upstream byte on the bus is sent and consumed
    // END      | good end of frame
    // EDB      | frame nullified after upstream underflow
    // PAD      | filler until the frame length is a multiple of ALIGN

    localparam int TW = (SKP_INTERVAL > 2) ? $clog2(SKP_INTERVAL) : 1;
    localparam int FW = (ALIGN > 2) ? $clog2(ALIGN) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(SKP_INTERVAL - 1);
    localparam logic [2:0]    SYM_LAST   = 3'(SKP_COUNT - 1);

    localparam logic [3:0] CODE_TLP = 4'b0000;
    localparam logic [3:0] CODE_COM = 4'b0001;
    localparam logic [3:0] CODE_PAD = 4'b0010;
    localparam logic [3:0] CODE_SKP = 4'b0011;
    localparam logic [3:0] CODE_STP = 4'b0100;
    localparam logic [3:0] CODE_END = 4'b0110;
    localparam logic [3:0] CODE_EDB = 4'b0111;
    localparam logic [3:0] CODE_IDL = 4'b1001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKP_COM,
        S_SKP_SYM,
        S_STP,
        S_DATA,
        S_END,
        S_EDB,
        S_PAD
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_inc;
    logic            skp_pend;
    logic [2:0]      sym_cnt;
    logic [FW-1:0]   frame_cnt;
    logic [FW-1:0]   frame_cnt_inc;
    logic            frame_aligned;
    logic            in_frame;

    function automatic logic [3:0] ctrl_code(input state_t s);
        case (s)
            S_SKP_COM: ctrl_code = CODE_COM;
            S_SKP_SYM: ctrl_code = CODE_SKP;
            S_STP:     ctrl_code = CODE_STP;
            S_DATA:    ctrl_code = CODE_TLP;
            S_END:     ctrl_code = CODE_END;
            S_EDB:     ctrl_code = CODE_EDB;
            S_PAD:     ctrl_code = CODE_PAD;
            default:   ctrl_code = CODE_IDL;
        endcase
    endfunction

    // frame_cnt holds the symbols already sent; the current symbol makes it frame_cnt+1
    assign timer_inc     = timer + 1'b1;
    assign frame_cnt_inc = frame_cnt + 1'b1;
    assign frame_aligned = (frame_cnt_inc == '0);
    assign in_frame      = (state == S_STP) || (state == S_DATA) || (state == S_END) ||
                           (state == S_EDB) || (state == S_PAD);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (skp_pend)
                    state_next = S_SKP_COM;
                else if (tlpVLD)
                    state_next = S_STP;
            end
            S_SKP_COM: state_next = S_SKP_SYM;
            S_SKP_SYM: begin
                if (sym_cnt == SYM_LAST)
                    state_next = S_IDLE;
            end
            S_STP: state_next = S_DATA;
            S_DATA: begin
                if (!tlpVLD)
                    state_next = S_EDB;
                else if (tlpLAST)
                    state_next = S_END;
            end
            S_END, S_EDB, S_PAD: begin
                state_next = frame_aligned ? S_IDLE : S_PAD;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge seqCLK or negedge seqRST_n) begin
        if (!seqRST_n) begin
            state     <= S_IDLE;
            muxCTRL   <= CODE_IDL;
            tlpRDY    <= 1'b0;
            seqBUSY   <= 1'b0;
            timer     <= '0;
            skp_pend  <= 1'b0;
            sym_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            state   <= state_next;
            muxCTRL <= ctrl_code(state_next);
            tlpRDY  <= (state_next == S_DATA);
            seqBUSY <= (state_next != S_IDLE);

            // timer saturates at TIMER_LAST with skp_pend held until the COM is issued
            if (state_next == S_SKP_COM) begin
                timer    <= '0;
                skp_pend <= 1'b0;
            end else if (timer != TIMER_LAST) begin
                timer <= timer_inc;
                if (timer_inc == TIMER_LAST)
                    skp_pend <= 1'b1;
            end

            if (state == S_SKP_COM)
                sym_cnt <= '0;
            else if (state == S_SKP_SYM)
                sym_cnt <= sym_cnt + 1'b1;

            if (state_next == S_STP)
                frame_cnt <= '0;
            else if (in_frame)
                frame_cnt <= frame_cnt_inc;
        end
    end

endmodule
